ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_sync_edge.sv | 33 +++
 rtl/ps2_host_tx.sv | 167 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, default timing, command codes.
package ps2_pkg;

    localparam int unsigned DEFAULT_INHIBIT_CYCLES = 5000;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 750000;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_FINISH
    } ps2_tx_state_e;

    // Odd parity: the frame carries an odd number of ones across data and parity.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a registered
// falling-edge strobe on the synchronized clock.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2c_in,
    input  logic ps2d_in,
    output logic ps2c_sync,
    output logic ps2d_sync,
    output logic ps2c_fall
);

    logic ps2c_meta;
    logic ps2d_meta;

    // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2c_meta <= 1'b1;
            ps2c_sync <= 1'b1;
            ps2d_meta <= 1'b1;
            ps2d_sync <= 1'b1;
            ps2c_fall <= 1'b0;
        end else begin
            ps2c_meta <= ps2c_in;
            ps2c_sync <= ps2c_meta;
            ps2d_meta <= ps2d_in;
            ps2d_sync <= ps2d_meta;
            ps2c_fall <= ps2c_sync & ~ps2c_meta;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, start, 8 data, parity, stop, ack).
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic INH_SINGLE = (INHIBIT_CYCLES <= 1);

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    ps2_tx_state_e    state;
    logic [INH_W-1:0] inh_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       data_q;
    logic             parity_q;
    logic             nack_q;

    logic ps2c_sync;
    logic ps2d_sync;
    logic ps2c_fall;

    ps2_sync_edge u_sync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2c_in   (ps2c_in),
        .ps2d_in   (ps2d_in),
        .ps2c_sync (ps2c_sync),
        .ps2d_sync (ps2d_sync),
        .ps2c_fall (ps2c_fall)
    );

    // Outputs are registered as the values seen while in the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            inh_cnt  <= '0;
            bit_cnt  <= '0;
            data_q   <= '0;
            parity_q <= 1'b0;
            nack_q   <= 1'b0;
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_ready <= 1'b1;
                    ps2c_oe  <= 1'b0;
                    ps2d_oe  <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        data_q   <= tx_data;
                        parity_q <= odd_parity(tx_data);
                        nack_q   <= 1'b0;
                        inh_cnt  <= '0;
                        ps2c_oe  <= 1'b1;
                        ps2d_oe  <= INH_SINGLE;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= ST_INHIBIT;
`ifdef PS2_TX_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b1;
                        state   <= ST_START;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                        if (inh_cnt == INH_PRE) begin
                            ps2d_oe <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    bit_cnt <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Edges 1..8 carry data LSB first, 9 parity, 10 releases data for stop.
                    if (ps2c_fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8) begin
                            ps2d_oe <= ~data_q[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            ps2d_oe <= ~parity_q;
                        end else begin
                            ps2d_oe <= 1'b0;
                            state   <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (ps2c_fall) begin
                        nack_q <= ps2d_sync;
                        state  <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (ps2c_sync && ps2d_sync) begin
                        tx_done  <= 1'b1;
                        tx_error <= nack_q;
                        state    <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    tx_done  <= 1'b0;
                    tx_error <= 1'b0;
                    tx_busy  <= 1'b0;
                    tx_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

`ifdef PS2_TX_TIMEOUT_EN
            // Watchdog overrides the normal transition once the device stalls too long.
            if (state == ST_START || state == ST_SHIFT ||
                state == ST_ACK   || state == ST_WAIT_IDLE) begin
                if (wd_cnt == WD_LAST) begin
                    ps2c_oe  <= 1'b0;
                    ps2d_oe  <= 1'b0;
                    tx_done  <= 1'b1;
                    tx_error <= 1'b1;
                    state    <= ST_FINISH;
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of
// the host and compares them with frames built from the byte, parity and framing rules.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned TB_INH  = 5000;
    localparam int unsigned TB_TO   = 20000;
    localparam int          HALF    = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2c_oe, ps2d_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_error;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       ps2c_line, ps2d_line;

    assign ps2c_line = ~ps2c_oe & ~dev_c_low;
    assign ps2d_line = ~ps2d_oe & ~dev_d_low;

    ps2_host_tx #(.INHIBIT_CYCLES(TB_INH), .TIMEOUT_CYCLES(TB_TO)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2c_in  (ps2c_line),
        .ps2d_in  (ps2d_line),
        .ps2c_oe  (ps2c_oe),
        .ps2d_oe  (ps2d_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_error (tx_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Passive monitor: done/error pulses, transfer starts, inhibit pulse shape.
    int done_cnt = 0, start_cnt = 0, stray_err = 0, ready_busy = 0;
    logic last_err = 1'b0, busy_q = 1'b0;
    int run = 0, overlap = 0, last_run = 0, last_overlap = 0;

    always @(posedge clk) begin
        #1;
        if (tx_done === 1'b1) begin
            done_cnt++;
            last_err = tx_error;
        end
        if (tx_error === 1'b1 && tx_done !== 1'b1) stray_err++;
        if (tx_ready === 1'b1 && tx_busy === 1'b1) ready_busy++;
        if (tx_busy === 1'b1 && busy_q !== 1'b1) start_cnt++;
        busy_q = tx_busy;
        if (ps2c_oe === 1'b1) begin
            run++;
            if (ps2d_oe === 1'b1) overlap++;
        end else if (run > 0) begin
            last_run = run;
            last_overlap = overlap;
            run = 0;
            overlap = 0;
        end
    end

    // Expected line frame {stop, parity, D7..D0, start} from the byte.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic do_send(input logic [7:0] d, output bit ok);
        @(negedge clk);
        tx_data = d;
        tx_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tx_busy === 1'b1) begin ok = 1'b1; break; end
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (done_cnt > prev) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // Device side: waits for request-to-send, then generates up to 11 clock pulses.
    task automatic dev_xfer(input int abort_after, input bit nack,
                            output logic [10:0] bits, output bit ok);
        int n;
        bits = '0;
        ok = 1'b0;
        n = 0;
        while (ps2c_line !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (ps2c_line !== 1'b0) return;
        n = 0;
        while (!(ps2c_line === 1'b1 && ps2d_line === 1'b0) && n < int'(TB_INH) + 200) begin
            @(negedge clk); n++;
        end
        if (!(ps2c_line === 1'b1 && ps2d_line === 1'b0)) return;
        repeat (5) @(negedge clk);
        bits[0] = ps2d_line;
        for (int k = 1; k <= 11; k++) begin
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k == abort_after) begin ok = 1'b1; return; end
            dev_c_low = 1'b0;
            if (k <= 10) bits[k] = ps2d_line;
            repeat (HALF / 2) @(negedge clk);
            if (k == 10 && !nack) dev_d_low = 1'b1;
            repeat (HALF - HALF / 2) @(negedge clk);
        end
        dev_d_low = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({ps2c_oe, ps2d_oe, tx_ready, tx_busy, tx_done, tx_error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {ps2c_oe, ps2d_oe, tx_ready, tx_busy, tx_done, tx_error});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: ready=%b busy=%b want 1 0", tx_ready, tx_busy);
        end
    endtask

    // Full transfer with frame, done/error and post-transfer idle checks.
    task automatic run_xfer(input string name, input logic [7:0] d, input bit nack);
        bit ok;
        int prev;
        logic [10:0] bits;
        prev = done_cnt;
        do_send(d, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_accept: busy never rose", name); end
        dev_xfer(0, nack, bits, ok);
        checks++;
        if (!ok || bits !== frame_of(d)) begin
            errors++;
            $display("FAIL %s_frame: got %b want %b (device ok=%0d)", name, bits, frame_of(d), ok);
        end
        wait_done(prev, 200, ok);
        checks++;
        if (!ok || done_cnt != prev + 1) begin
            errors++;
            $display("FAIL %s_done: done count %0d want %0d", name, done_cnt, prev + 1);
        end
        checks++;
        if (last_err !== nack) begin
            errors++;
            $display("FAIL %s_error: got %b want %b", name, last_err, nack);
        end
        @(posedge clk); #1;
        checks++;
        if ({tx_ready, tx_busy, ps2c_oe, ps2d_oe} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_idle: ready/busy/c_oe/d_oe=%b want 1000",
                     name, {tx_ready, tx_busy, ps2c_oe, ps2d_oe});
        end
    endtask

    task automatic test_set_leds;
        run_xfer("set_leds", PS2_CMD_SET_LEDS, 1'b0);
        checks++;
        if (frame_of(PS2_CMD_SET_LEDS) !== 11'b1_1_11101101_0) begin
            errors++;
            $display("FAIL set_leds_model: got %b want 11111011010", frame_of(PS2_CMD_SET_LEDS));
        end
    endtask

    task automatic test_parity_07;
        run_xfer("cmd07", 8'h07, 1'b0);
        checks++;
        if (last_run != int'(TB_INH) || last_overlap != 1) begin
            errors++;
            $display("FAIL inhibit_shape: clk low %0d cycles, data overlap %0d; want %0d and 1",
                     last_run, last_overlap, TB_INH);
        end
    endtask

    task automatic test_nack;
        run_xfer("nack", 8'($urandom_range(0, 255)), 1'b1);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int prev;
        logic [10:0] bits;
        prev = done_cnt;
        do_send(8'hFF, ok);
        dev_xfer(4, 1'b0, bits, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_device: no start condition"); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ps2c_oe, ps2d_oe, tx_busy, tx_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_release: c_oe/d_oe/busy/ready=%b want 0000",
                     {ps2c_oe, ps2d_oe, tx_busy, tx_ready});
        end
        dev_c_low = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt != prev) begin
            errors++;
            $display("FAIL midreset_no_done: done count %0d want %0d", done_cnt, prev);
        end
        run_xfer("after_reset", 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back;
        bit ok;
        int pd, ps;
        logic [10:0] bits;
        logic [7:0] a, b;
        a = 8'($urandom_range(0, 255));
        b = ~a;
        pd = done_cnt;
        ps = start_cnt;
        @(negedge clk);
        tx_data = a;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_data = b;
        dev_xfer(0, 1'b0, bits, ok);
        checks++;
        if (!ok || bits !== frame_of(a)) begin
            errors++;
            $display("FAIL b2b_first_frame: got %b want %b", bits, frame_of(a));
        end
        wait_done(pd, 200, ok);
        checks++;
        if (!ok || start_cnt != ps + 1) begin
            errors++;
            $display("FAIL b2b_single_accept: starts %0d want %0d before done", start_cnt - ps, 1);
        end
        for (int n = 0; n < 20 && start_cnt < ps + 2; n++) @(negedge clk);
        tx_valid = 1'b0;
        dev_xfer(0, 1'b0, bits, ok);
        checks++;
        if (!ok || bits !== frame_of(b)) begin
            errors++;
            $display("FAIL b2b_second_frame: got %b want %b", bits, frame_of(b));
        end
        wait_done(pd + 1, 200, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (start_cnt != ps + 2 || done_cnt != pd + 2) begin
            errors++;
            $display("FAIL b2b_counts: starts %0d dones %0d want 2 2", start_cnt - ps, done_cnt - pd);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 2; i++) begin
            run_xfer("random", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        int prev;
        prev = done_cnt;
        do_send(8'h5A, ok);
        wait_done(prev, int'(TB_INH + TB_TO) + 500, ok);
        checks++;
        if (!ok || last_err !== 1'b1 || ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin
            errors++;
            $display("FAIL timeout_finish: done=%0d err=%b c_oe=%b d_oe=%b want 1 1 0 0",
                     ok, last_err, ps2c_oe, ps2d_oe);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ready: got %b want 1", tx_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_set_leds();
        test_parity_07();
        test_nack();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef PS2_TX_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (stray_err != 0 || ready_busy != 0) begin
            errors++;
            $display("FAIL handshake_rules: stray errors %0d, ready&busy cycles %0d, want 0 0",
                     stray_err, ready_busy);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
